vsync: RTL

Vertical timing stage for the 640x480@60 VGA output. It sits directly downstream of the horizontal sync generator and consumes its `o_hsync` on the same pixel clock. It counts scan lines from hsync pulses and produces the active-low vertical sync, the current row index, a visible-row flag and a one-cycle frame-start strobe for the pixel/pattern stages.

---
 rtl/vsync.sv | 91 +++++++++
 1 files changed

// File: rtl/vsync.sv
// vsync - vertical timing stage for 640x480@60 VGA.
//
// Counts scan lines from the falling edge of the upstream active-low hsync
// and produces the vertical sync, row index, visible-row flag and a
// frame-start strobe. All outputs are registered.
//
// Optional feature: define VSYNC_FRAME_COUNT_EN to build a 16-bit frame
// counter on o_frame_count; otherwise o_frame_count is tied to zero.
//
// Ports:
//   i_clock        pixel clock, shared with the hsync generator
//   i_reset        asynchronous, active-high reset
//   i_hsync        upstream hsync, active low, already in i_clock domain
//   o_vsync        vertical sync, active low
//   o_row          current line, 0 .. total-1
//   o_row_active   high while o_row < V_VIDEO
//   o_frame_start  one-cycle strobe when o_row wraps to 0
//   o_frame_count  frame counter (zero unless VSYNC_FRAME_COUNT_EN)
module vsync #(
  parameter int V_VIDEO       = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_PULSE       = 2,
  parameter int V_BACK_PORCH  = 33
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_hsync,
  output logic        o_vsync,
  output logic [9:0]  o_row,
  output logic        o_row_active,
  output logic        o_frame_start,
  output logic [15:0] o_frame_count
);

  localparam int V_TOTAL = V_VIDEO + V_FRONT_PORCH + V_PULSE + V_BACK_PORCH;

  localparam logic [9:0] ROW_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] ROW_VIDEO  = 10'(V_VIDEO);
  localparam logic [9:0] ROW_VS_BEG = 10'(V_VIDEO + V_FRONT_PORCH);
  localparam logic [9:0] ROW_VS_END = 10'(V_VIDEO + V_FRONT_PORCH + V_PULSE - 1);

  logic       r_hsync_d;
  logic       line_tick;
  logic       row_wrap;
  logic [9:0] row_next;

  // A line starts on the falling edge of hsync.
  assign line_tick = r_hsync_d & ~i_hsync;
  assign row_wrap  = line_tick && (o_row == ROW_LAST);

  // Explicit wrap at total-1; the 10-bit counter never relies on overflow.
  always_comb begin
    row_next = o_row;
    if (line_tick) begin
      if (o_row == ROW_LAST) row_next = 10'd0;
      else                   row_next = o_row + 10'd1;
    end
  end

  // Flags are derived from row_next so they change on the same edge as o_row.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hsync_d     <= 1'b1;
      o_row         <= 10'd0;
      o_vsync       <= 1'b1;
      o_row_active  <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      r_hsync_d     <= i_hsync;
      o_row         <= row_next;
      o_vsync       <= !((row_next >= ROW_VS_BEG) && (row_next <= ROW_VS_END));
      o_row_active  <= (row_next < ROW_VIDEO);
      o_frame_start <= row_wrap;
    end
  end

`ifdef VSYNC_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Increments on the edge that raises o_frame_start; wraps naturally at 16 bits.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)       r_frame_count <= 16'h0000;
    else if (row_wrap) r_frame_count <= r_frame_count + 16'h0001;
  end

  assign o_frame_count = r_frame_count;
`else
  assign o_frame_count = 16'h0000;
`endif

endmodule
